// File: rtl/hdlverifier_playback_data.sv
// Playback buffer: serial words from the JTAG controller are packed into an
// internal RAM and later replayed to the user design, one word per clock enable.
module hdlverifier_playback_data #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  shift_in_state,
  input  logic                  shift_in_en,
  input  logic                  shift_in_data,
  input  logic                  run,
  input  logic                  loop,
  input  logic [ADDR_WIDTH-1:0] window_size,
  input  logic                  clk_enable,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  data_valid,
  output logic                  flag_done,
  output logic                  flag_overflow,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int BC_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BC_W-1:0]     BC_LAST = BC_W'(DATA_WIDTH - 1);
  localparam logic [ADDR_WIDTH:0] FULL    = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DONE} state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] r_shift_reg;
  logic [BC_W-1:0]       r_bitcount;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [ADDR_WIDTH-1:0] r_raddr;
  logic [ADDR_WIDTH-1:0] r_win_q;
  logic [ADDR_WIDTH:0]   r_words_loaded;
  logic                  r_run_d1;
  logic                  r_sis_d1;
  logic                  r_data_valid;
  logic                  r_flag_done;
  logic                  r_flag_overflow;

  logic [DATA_WIDTH-1:0] w_shift_word;
  logic                  w_word_done;
  logic                  w_has_room;
  logic                  w_we;
  logic                  w_rd_en;
  logic                  w_run_rise;

  // The incoming bit enters at the MSB so the first bit shifted lands in the LSB.
  assign w_shift_word = {shift_in_data, r_shift_reg[DATA_WIDTH-1:1]};
  assign w_word_done  = (r_state == S_IDLE) && shift_in_state && shift_in_en &&
                        (r_bitcount == BC_LAST);
  // Writes are gated by the word count, so waddr wrapping never overwrites.
  assign w_has_room   = (r_words_loaded < FULL);
  assign w_we         = reset && w_word_done && w_has_room;
  assign w_rd_en      = reset && (r_state == S_PLAY) && run && clk_enable;
  assign w_run_rise   = run && !r_run_d1;

  // RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[r_waddr] <= w_shift_word;
    end
  end

  // Registered RAM read feeding the played-back word; holds when not enabled.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_data <= '0;
    end else if (w_rd_en) begin
      r_data <= r_mem[r_raddr];
    end
  end

  // Control FSM: load path in IDLE, sequencing in PLAY, handshake in DONE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state         <= S_IDLE;
      r_shift_reg     <= '0;
      r_bitcount      <= '0;
      r_waddr         <= '0;
      r_raddr         <= '0;
      r_win_q         <= '0;
      r_words_loaded  <= '0;
      r_run_d1        <= 1'b0;
      r_sis_d1        <= 1'b0;
      r_data_valid    <= 1'b0;
      r_flag_done     <= 1'b0;
      r_flag_overflow <= 1'b0;
    end else begin
      r_run_d1 <= run;
      r_sis_d1 <= shift_in_state;
      case (r_state)
        S_IDLE: begin
          r_data_valid <= 1'b0;
          if (!shift_in_state) begin
            // Leaving shift-in discards any partial word.
            r_bitcount  <= '0;
            r_shift_reg <= '0;
          end else begin
            if (!r_sis_d1) begin
              r_waddr         <= '0;
              r_words_loaded  <= '0;
              r_flag_overflow <= 1'b0;
            end
            if (shift_in_en) begin
              r_shift_reg <= w_shift_word;
              if (r_bitcount == BC_LAST) begin
                r_bitcount <= '0;
                if (w_has_room) begin
                  r_waddr        <= r_waddr + 1'b1;
                  r_words_loaded <= r_words_loaded + 1'b1;
                end else begin
                  r_flag_overflow <= 1'b1;
                end
              end else begin
                r_bitcount <= r_bitcount + 1'b1;
              end
            end
          end
          // A completing word is still written above; playback starts after it.
          if (w_run_rise) begin
            r_win_q     <= window_size;
            r_raddr     <= '0;
            r_bitcount  <= '0;
            r_shift_reg <= '0;
            r_state     <= S_PLAY;
          end
        end
        S_PLAY: begin
          if (!run) begin
            r_data_valid <= 1'b0;
            r_state      <= S_IDLE;
          end else if (clk_enable) begin
            r_data_valid <= 1'b1;
            if (r_raddr == r_win_q) begin
              if (loop) begin
                r_raddr <= '0;
              end else begin
                r_state     <= S_DONE;
                r_flag_done <= 1'b1;
              end
            end else begin
              r_raddr <= r_raddr + 1'b1;
            end
          end else begin
            r_data_valid <= 1'b0;
          end
        end
        S_DONE: begin
          r_data_valid <= 1'b0;
          // run must fall before another rising edge can start playback.
          if (!run) begin
            r_flag_done <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign data          = r_data;
  assign data_valid    = r_data_valid;
  assign flag_done     = r_flag_done;
  assign flag_overflow = r_flag_overflow;
  assign words_loaded  = r_words_loaded;

endmodule

// File: tb/tb_hdlverifier_playback_data.sv
// Scoreboard bench: expected playback words are queued when a run is set up
// and compared whenever the block presents a valid word.
module tb_hdlverifier_playback_data;

  localparam int DW = 8;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          shift_in_state;
  logic          shift_in_en;
  logic          shift_in_data;
  logic          run;
  logic          loop;
  logic [AW-1:0] window_size;
  logic          clk_enable;
  logic [DW-1:0] data;
  logic          data_valid;
  logic          flag_done;
  logic          flag_overflow;
  logic [AW:0]   words_loaded;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [DW-1:0] exp_q[$];

  hdlverifier_playback_data #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .shift_in_state(shift_in_state),
    .shift_in_en(shift_in_en), .shift_in_data(shift_in_data), .run(run),
    .loop(loop), .window_size(window_size), .clk_enable(clk_enable),
    .data(data), .data_valid(data_valid), .flag_done(flag_done),
    .flag_overflow(flag_overflow), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every valid word must match the head of the queue.
  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("extra_word", 32'(data), 32'hFFFF_FFFF);
      else                   chk("word", 32'(data), 32'(exp_q.pop_front()));
    end
  end

  task automatic start_session();
    shift_in_state = 1'b0; shift_in_en = 1'b0;
    tick();
    shift_in_state = 1'b1;
  endtask

  task automatic end_session();
    shift_in_en = 1'b0; shift_in_state = 1'b0;
    tick();
  endtask

  task automatic shift_word(input logic [DW-1:0] w);
    for (int i = 0; i < DW; i++) begin
      shift_in_en = 1'b1; shift_in_data = w[i];
      tick();
    end
    shift_in_en = 1'b0;
  endtask

  // Non-loop playback of queued words; waits (bounded) for flag_done.
  task automatic play(input int win);
    int cyc;
    window_size = AW'(win); loop = 1'b0; clk_enable = 1'b1; run = 1'b1;
    cyc = 0;
    tick();
    while (flag_done !== 1'b1 && cyc < 80) begin
      tick();
      cyc++;
    end
    chk("play_done", 32'(flag_done), 32'd1);
    run = 1'b0;
    tick();
    tick();
    chk("play_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; shift_in_state = 1'b0; shift_in_en = 1'b0; shift_in_data = 1'b0;
    run = 1'b0; loop = 1'b0; window_size = '0; clk_enable = 1'b0;
    tick(); tick();
    reset = 1'b1;
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_valid", 32'(data_valid), 32'd0);
    chk("rst_done", 32'(flag_done), 32'd0);
    chk("rst_ovf", 32'(flag_overflow), 32'd0);
    chk("rst_wl", 32'(words_loaded), 32'd0);
    tick();

    // Two words, LSB first.
    start_session(); shift_word(8'hA5); shift_word(8'h3C); end_session();
    chk("wl_two", 32'(words_loaded), 32'd2);
    exp_q.push_back(8'hA5); exp_q.push_back(8'h3C);
    play(1);

    // Four words, latency and done behaviour.
    start_session();
    for (int i = 1; i <= 4; i++) shift_word(DW'(i));
    end_session();
    chk("wl_four", 32'(words_loaded), 32'd4);
    for (int i = 1; i <= 4; i++) exp_q.push_back(DW'(i));
    window_size = 3; loop = 1'b0; clk_enable = 1'b1; run = 1'b1;
    tick();
    chk("lat_edge1_valid", 32'(data_valid), 32'd0);
    tick();
    chk("lat_edge2_valid", 32'(data_valid), 32'd1);
    tick(); tick(); tick();
    chk("last_done", 32'(flag_done), 32'd1);
    tick();
    chk("done_valid", 32'(data_valid), 32'd0);
    chk("done_hold", 32'(data), 32'h04);
    chk("done_flag", 32'(flag_done), 32'd1);
    chk("seq_drained", 32'(exp_q.size()), 32'd0);
    run = 1'b0;
    tick(); tick();
    chk("done_clear", 32'(flag_done), 32'd0);

    // Toggling clock enable.
    for (int i = 1; i <= 4; i++) exp_q.push_back(DW'(i));
    window_size = 3; run = 1'b1; clk_enable = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      clk_enable = (i % 2 == 0);
      tick();
      chk("ce_valid", 32'(data_valid), 32'(clk_enable));
      if (!clk_enable) chk("ce_hold", 32'(data), 32'(i / 2 + 1));
    end
    chk("ce_done", 32'(flag_done), 32'd1);
    run = 1'b0;
    tick(); tick();
    chk("ce_drained", 32'(exp_q.size()), 32'd0);

    // Loop mode, aborted by dropping run.
    for (int i = 0; i < 10; i++) exp_q.push_back(DW'(i % 4 + 1));
    window_size = 3; loop = 1'b1; clk_enable = 1'b1; run = 1'b1;
    tick();
    repeat (10) tick();
    run = 1'b0;
    tick();
    chk("abort_valid", 32'(data_valid), 32'd0);
    chk("abort_done", 32'(flag_done), 32'd0);
    chk("loop_drained", 32'(exp_q.size()), 32'd0);
    tick();

    // Reset mid-playback; RAM survives.
    exp_q.push_back(8'h01);
    window_size = 3; loop = 1'b1; run = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("mid_rst_valid", 32'(data_valid), 32'd0);
    chk("mid_rst_data", 32'(data), 32'd0);
    chk("mid_rst_wl", 32'(words_loaded), 32'd0);
    reset = 1'b1; run = 1'b0;
    tick();
    exp_q.push_back(8'h01);
    play(0);

    // Overflow: 33 words into a 32-deep buffer.
    start_session();
    for (int i = 0; i < 33; i++) shift_word(DW'(8'h40 + i));
    end_session();
    chk("ovf_wl", 32'(words_loaded), 32'd32);
    chk("ovf_flag", 32'(flag_overflow), 32'd1);
    exp_q.push_back(8'h40);
    play(0);
    start_session();
    tick();
    chk("ovf_clear", 32'(flag_overflow), 32'd0);
    chk("ovf_wl_clear", 32'(words_loaded), 32'd0);
    end_session();

    // Partial word is discarded; slot 4 keeps its stale value.
    start_session();
    for (int i = 1; i <= 4; i++) shift_word(DW'(i));
    for (int i = 0; i < 5; i++) begin
      shift_in_en = 1'b1; shift_in_data = 1'b1;
      tick();
    end
    end_session();
    chk("partial_wl", 32'(words_loaded), 32'd4);
    for (int i = 1; i <= 4; i++) exp_q.push_back(DW'(i));
    exp_q.push_back(8'h44);
    play(4);

    // Shift activity during PLAY is ignored.
    window_size = 3; loop = 1'b1; clk_enable = 1'b0; run = 1'b1;
    tick();
    shift_in_state = 1'b1;
    shift_word(8'hFF);
    shift_in_state = 1'b0;
    tick();
    run = 1'b0;
    tick();
    chk("play_shift_wl", 32'(words_loaded), 32'd4);
    for (int i = 1; i <= 4; i++) exp_q.push_back(DW'(i));
    play(3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/hdlverifier_playback_data.md
Name: hdlverifier_playback_data

Overview:
Stimulus-injection counterpart of the capture buffer. The JTAG controller, already synchronized into the user clock domain, shifts serial words into an internal RAM. The block then plays those words back to the user's design, one word per clock-enable, after a run request. It sits between the JTAG controller and the DUT input, in the same single clock domain as the DUT.

Parameters:
DATA_WIDTH, 8, width of each played-back word
ADDR_WIDTH, 5, buffer address width; depth = 2**ADDR_WIDTH words

Ports:
clk  input  1  user design clock; the only clock
reset  input  1  synchronous, active-low reset
shift_in_state  input  1  1 = controller in shift-in state; 0 = idle/clear
shift_in_en  input  1  one serial bit valid on shift_in_data this cycle
shift_in_data  input  1  serial load bit, LSB of each word first
run  input  1  playback request; level, rising edge starts playback
loop  input  1  1 = wrap to word 0 after the last word instead of stopping
window_size  input  ADDR_WIDTH  number of words to play minus 1
clk_enable  input  1  DUT clock enable; one word advanced per enabled cycle
data  output  DATA_WIDTH  played-back word to DUT
data_valid  output  1  data holds a new word this cycle
flag_done  output  1  playback finished (non-loop mode)
flag_overflow  output  1  sticky; more words shifted in than buffer depth
words_loaded  output  ADDR_WIDTH+1  count of complete words written since load start

Behaviour:
- Reset (reset==0 at a clk edge) returns to IDLE and clears the registers.
  - data=0, data_valid=0, flag_done=0, flag_overflow=0, words_loaded=0.
  - Internal: bitcount=0, shift_reg=0, waddr=0, raddr=0, run_d1=0.
  - RAM contents are not cleared.
  - Reset mid-load or mid-playback aborts immediately.
- States:
  - IDLE: loading permitted. run_d1<=run. A rising edge of run (run && !run_d1) latches window_size into win_q, sets raddr=0, clears bitcount/shift_reg, and goes to PLAY.
  - PLAY: playback.
  - DONE: flag_done=1. When run==0, go to IDLE and clear flag_done.
- Load path (IDLE only; shift inputs are ignored in PLAY/DONE):
  - shift_in_state==0: bitcount=0, shift_reg=0.
  - The first cycle with shift_in_state==1 after it was 0 also clears waddr, words_loaded and flag_overflow.
  - shift_in_state==1 && shift_in_en: shift_reg <= {shift_in_data, shift_reg[DATA_WIDTH-1:1]}; bitcount++.
  - When bitcount==DATA_WIDTH-1 on an enabled bit, the word is complete:
    - If words_loaded < 2**ADDR_WIDTH: write {shift_in_data, shift_reg[DATA_WIDTH-1:1]} to mem[waddr], then waddr++ and words_loaded++.
    - Otherwise drop the word and set flag_overflow.
    - In both cases bitcount=0.
  - waddr wraps naturally, but writes are gated by words_loaded, so no wrap overwrite occurs.
  - A partial word left when shift_in_state falls is discarded.
- Playback (PLAY):
  - Read is synchronous.
  - Cycle with clk_enable=1: data <= mem[raddr], data_valid<=1 on the next edge, i.e. latency 1 clk from the enabled cycle.
  - Then:
    - If raddr==win_q and loop==1: raddr<=0.
    - If raddr==win_q and loop==0: go to DONE.
    - Otherwise raddr++.
  - Cycle with clk_enable=0: data_valid<=0 and data holds its value.
  - run==0 while in PLAY aborts to IDLE: data_valid<=0, data holds, flag_done stays 0.
  - loop is sampled every enabled cycle.
  - window_size changes during PLAY have no effect because win_q is latched.
  - window_size >= words_loaded is not checked; stale RAM words are played.
- In DONE: data_valid=0 and data holds the last word.
- Simultaneous events:
  - A run rising edge in the same cycle as a completing shift word: the word write completes first, then the block enters PLAY.
  - A run rising edge in DONE is not seen; run must return low (back to IDLE) first.

Test Plan:
- Reset low for 2 clk, then release → all outputs 0, state IDLE. Drive reset low mid-PLAY → data_valid=0 on the next edge and return to IDLE.
- DATA_WIDTH=8: shift in 0xA5 then 0x3C LSB-first with shift_in_en every cycle → words_loaded=2, mem[0]=0xA5, mem[1]=0x3C.
- Load 0x01..0x04, window_size=3, loop=0, clk_enable=1, raise run → data=0x01,0x02,0x03,0x04 with data_valid=1 on 4 consecutive cycles starting 2 clk after the run edge, then flag_done=1 and data holds 0x04. Drop run → flag_done=0.
- Same load, clk_enable toggling 1,0,1,0 → data_valid pattern 1,0,1,0 and data advances only after enabled cycles. loop=1 → sequence 01,02,03,04,01,02… until run=0.
- ADDR_WIDTH=5: shift in 33 words → words_loaded=32, flag_overflow=1, mem[0] unchanged by the 33rd word. A new shift_in_state rise → flag_overflow=0, words_loaded=0.
- Shift in 5 bits, then drop shift_in_state → no write, words_loaded unchanged. Pulse shift_in_en during PLAY → RAM and words_loaded unchanged.
